// File: rtl/vad_pretrigger_reader.sv
// vad_pretrigger_reader
// Captures every audio sample into a circular buffer. When the VAD opens a
// session it replays up to PRE_TRIGGER_SAMPLES of history, then streams live
// audio on a valid/ready port. The newest owed word is always held back
// while the session is live, so the closing word can carry out_last.
//
// Read pipeline: one BRAM output register (q stage) feeding the output
// register. Words in those two stages are "in flight"; remaining counts
// them as well as the owed words still sitting in memory.
module vad_pretrigger_reader #(
  parameter int DATA_W              = 16,
  parameter int ADDR_W              = 12,
  parameter int PRE_TRIGGER_SAMPLES = 3200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              sample_valid,
  input  logic              recording_active,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   fill_level
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   PRE_C   = (ADDR_W + 1)'(PRE_TRIGGER_SAMPLES);
  localparam logic [ADDR_W:0]   ONE_R   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_q;
  logic [ADDR_W-1:0]   wp;
  logic [ADDR_W-1:0]   rp;
  logic [ADDR_W:0]     hist;
  logic [ADDR_W:0]     remaining;
  logic                q_valid;
  logic                q_last;

  logic                xfer;
  logic                move;
  logic                q_free;
  logic                drain_mode;
  logic                count_write;
  logic                fetch;
  logic                fetch_ok;
  logic                drop;
  logic                drop_dec;
  logic                fetch_last;
  logic                drop_last;
  logic [ADDR_W:0]     inflight;
  logic [ADDR_W:0]     owed_mem;
  logic [ADDR_W:0]     owed_post;
  logic [ADDR_W:0]     n_trig;
  logic [ADDR_W:0]     remaining_next;
  logic [ADDR_W-1:0]   rp_post;
  logic [ADDR_W-1:0]   rp_next;

  assign busy       = (state != IDLE);
  assign fill_level = remaining;

  // Fetch / drop decisions for this cycle, derived from registered state
  always_comb begin
    xfer        = out_valid & out_ready;
    move        = q_valid & (~out_valid | xfer);
    q_free      = ~q_valid | move;
    // Once the VAD drops, the held-back word becomes fetchable immediately.
    drain_mode  = (state == DRAIN) | ((state == STREAM) & ~recording_active);
    count_write = sample_valid & (state == STREAM) & recording_active;
    inflight    = {{ADDR_W{1'b0}}, out_valid} + {{ADDR_W{1'b0}}, q_valid};
    owed_mem    = remaining - inflight;
    fetch_ok    = drain_mode ? (owed_mem != '0) : (owed_mem > ONE_R);
    fetch       = (state != IDLE) & q_free & fetch_ok;
    owed_post   = owed_mem - {{ADDR_W{1'b0}}, fetch};
    rp_post     = rp + {{(ADDR_W-1){1'b0}}, fetch};
    drop        = 1'b0;
    if (count_write) begin
      // A counted write may never push the session past DEPTH owed words;
      // the oldest word still in memory makes room for it.
      drop = (remaining == DEPTH_C) & ~xfer;
    end else if (sample_valid && state != IDLE) begin
      // Uncounted write physically landing on the oldest owed word.
      drop = (wp == rp_post) & (owed_post != '0);
    end
    drop_dec    = drop & ~count_write;
    // Fetching the newest owed word in drain mode: that word closes the session.
    fetch_last  = fetch & drain_mode & (owed_post == '0);
    // Dropping the last owed memory word: the word waiting in q is now newest.
    drop_last   = drop & drain_mode & (owed_post == ONE_R);
    n_trig      = (hist < PRE_C) ? hist : PRE_C;
    remaining_next = remaining
                   + {{ADDR_W{1'b0}}, count_write & ~drop}
                   - {{ADDR_W{1'b0}}, xfer}
                   - {{ADDR_W{1'b0}}, drop_dec};
    rp_next     = rp_post + {{(ADDR_W-1){1'b0}}, drop};
  end

  // Buffer storage: write port for audio, registered read port for the q stage
  always_ff @(posedge clk) begin
    if (sample_valid) mem[wp] <= audio_in;
    if (fetch)        mem_q   <= mem[rp];
  end

  // Session control: pointers, history, owed-word count and state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      hist      <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      if (sample_valid) wp <= wp + ONE_A;
      if (state == DRAIN && xfer && out_last) begin
        hist <= '0;
      end else if (sample_valid && hist != DEPTH_C) begin
        hist <= hist + ONE_R;
      end
      unique case (state)
        IDLE: begin
          if (recording_active) begin
            state     <= STREAM;
            rp        <= wp - n_trig[ADDR_W-1:0];
            remaining <= n_trig + {{ADDR_W{1'b0}}, sample_valid};
            overflow  <= 1'b0;
          end
        end
        STREAM: begin
          rp        <= rp_next;
          remaining <= remaining_next;
          if (drop) overflow <= 1'b1;
          if (!recording_active) state <= DRAIN;
        end
        DRAIN: begin
          rp        <= rp_next;
          remaining <= remaining_next;
          if (drop) overflow <= 1'b1;
          if (remaining == '0 || (xfer && out_last)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage read pipeline: q stage behind the BRAM, then the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid   <= 1'b0;
      q_last    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (move) begin
        out_valid <= 1'b1;
        out_data  <= mem_q;
        out_last  <= q_last;
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (fetch) begin
        q_valid <= 1'b1;
        q_last  <= fetch_last;
      end else if (move) begin
        q_valid <= 1'b0;
        q_last  <= 1'b0;
      end
      if (drop_last) q_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vad_pretrigger_reader.sv
// Testbench for vad_pretrigger_reader: table-driven replay sessions plus
// hand-written sequences for overflow, back-to-back sessions, random
// back-pressure and reset in mid-session.
module tb_vad_pretrigger_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] audio_in;
  logic        sample_valid;
  logic        recording_active;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overflow;
  logic [12:0] fill_level;

  vad_pretrigger_reader #(.DATA_W(16), .ADDR_W(12), .PRE_TRIGGER_SAMPLES(3200)) dut (
    .clk(clk), .rst(rst), .audio_in(audio_in), .sample_valid(sample_valid),
    .recording_active(recording_active), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .overflow(overflow),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int idx   = 0;
  int fill_max = 0;
  int got_data[$];
  bit got_last[$];
  bit          prev_hold = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  typedef struct {
    int pre;
    int live;
    int exp_count;
    int exp_first;
    int exp_lastval;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: collect transfers, track fill_level and check output stability
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (int'(fill_level) > fill_max) fill_max = int'(fill_level);
      if (prev_hold) begin
        tests++;
        if (!out_valid || out_data != prev_data || out_last != prev_last) begin
          fails++;
          $display("FAIL stall_hold: got v=%0d d=%0d l=%0d, expected v=1 d=%0d l=%0d",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        got_data.push_back(int'(out_data));
        got_last.push_back(out_last);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    recording_active = 1'b0;
    out_ready = 1'b0;
    audio_in = '0;
    tick();
    tick();
    rst = 1'b0;
    idx = 0;
    tick();
    got_data.delete();
    got_last.delete();
    fill_max = 0;
  endtask

  task automatic send(input int n, input bit act, input bit rnd_gap, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      if (rnd_gap) begin
        while ($urandom_range(1, 0) == 0) begin
          sample_valid = 1'b0;
          recording_active = act;
          if (rnd_ready) out_ready = 1'($urandom_range(1, 0));
          tick();
        end
      end
      audio_in = idx[15:0];
      sample_valid = 1'b1;
      recording_active = act;
      if (rnd_ready) out_ready = 1'($urandom_range(1, 0));
      tick();
      idx++;
    end
    sample_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd_ready);
    recording_active = 1'b0;
    out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    for (int c = 0; c < 20000; c++) begin
      tick();
      if (!busy) break;
      if (rnd_ready) out_ready = 1'($urandom_range(1, 0));
    end
    chk("drain_done_busy", int'(busy), 0);
    out_ready = 1'b1;
    tick();
  endtask

  function automatic int count_lasts();
    int n = 0;
    foreach (got_last[i]) if (got_last[i]) n++;
    return n;
  endfunction

  function automatic int count_breaks(input int from);
    int n = 0;
    for (int i = from + 1; i < got_data.size(); i++)
      if (got_data[i] != got_data[i-1] + 1) n++;
    return n;
  endfunction

  // Compare collected words against exp[0..] and return mismatch count
  function automatic int seq_mismatch(input int exp[$]);
    int n = 0;
    if (exp.size() != got_data.size()) return 1 + exp.size() + got_data.size();
    foreach (exp[i]) if (exp[i] != got_data[i]) n++;
    return n;
  endfunction

  initial begin
    int exp[$];
    int lb;
    vecs[0] = '{5000, 100, 3300, 1800, 5099};
    vecs[1] = '{500,  20,  520,  0,    519};
    vecs[2] = '{0,    10,  10,   0,    9};
    vecs[3] = '{3200, 1,   3201, 0,    3200};
    vecs[4] = '{3201, 0,   3200, 1,    3200};
    vecs[5] = '{0,    0,   0,    0,    0};

    // Reset state
    do_reset();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_fill_level", int'(fill_level), 0);

    // Table-driven replay sessions
    foreach (vecs[v]) begin
      do_reset();
      out_ready = 1'b1;
      send(vecs[v].pre, 1'b0, 1'b0, 1'b0);
      if (vecs[v].live > 0) begin
        send(vecs[v].live, 1'b1, 1'b0, 1'b0);
      end else begin
        recording_active = 1'b1;
        tick();
      end
      drain(1'b0);
      $display("[TB] vec %0d pre=%0d live=%0d words=%0d", v, vecs[v].pre, vecs[v].live, got_data.size());
      chk($sformatf("vec%0d_count", v), got_data.size(), vecs[v].exp_count);
      if (vecs[v].exp_count > 0 && got_data.size() > 0) begin
        chk($sformatf("vec%0d_first", v), got_data[0], vecs[v].exp_first);
        chk($sformatf("vec%0d_lastval", v), got_data[got_data.size()-1], vecs[v].exp_lastval);
        chk($sformatf("vec%0d_lastflag", v), int'(got_last[got_last.size()-1]), 1);
      end
      chk($sformatf("vec%0d_breaks", v), count_breaks(0), 0);
      chk($sformatf("vec%0d_nlast", v), count_lasts(), (vecs[v].exp_count > 0) ? 1 : 0);
      chk($sformatf("vec%0d_overflow", v), int'(overflow), 0);
    end

    // Overflow while stalled: 100 history + 4200 live, out_ready low
    do_reset();
    out_ready = 1'b1;
    send(100, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(4200, 1'b1, 1'b0, 1'b0);
    chk("ovf_fill_level", int'(fill_level), 4096);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_out_held_valid", int'(out_valid), 1);
    chk("ovf_out_held_data", int'(out_data), 0);
    drain(1'b0);
    $display("[TB] overflow session words=%0d", got_data.size());
    lb = 0;
    for (int i = 1; i < got_data.size(); i++) if (got_data[i] <= got_data[i-1]) lb++;
    chk("ovf_monotonic_violations", lb, 0);
    if (got_data.size() > 0) chk("ovf_lastval", got_data[got_data.size()-1], 4299);
    chk("ovf_tail_breaks", count_breaks((got_data.size() > 4090) ? got_data.size() - 4090 : 0), 0);
    chk("ovf_fill_max_gt_depth", int'(fill_max > 4096), 0);
    chk("ovf_nlast", count_lasts(), 1);
    chk("ovf_flag_sticky", int'(overflow), 1);

    // Back-to-back sessions: writes during a stalled drain, VAD re-asserts early
    do_reset();
    out_ready = 1'b1;
    send(200, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(30, 1'b1, 1'b0, 1'b0);
    send(50, 1'b0, 1'b0, 1'b0);
    recording_active = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (count_lasts() == 1) break;
      tick();
    end
    chk("ab_a_done", count_lasts(), 1);
    tick(); tick(); tick();
    send(10, 1'b1, 1'b0, 1'b0);
    drain(1'b0);
    $display("[TB] sessions A+B words=%0d", got_data.size());
    exp.delete();
    for (int i = 0; i < 230; i++) exp.push_back(i);
    for (int i = 280; i < 290; i++) exp.push_back(i);
    chk("ab_seq_mismatches", seq_mismatch(exp), 0);
    chk("ab_nlast", count_lasts(), 2);
    if (got_last.size() == 240) begin
      chk("ab_last_a_pos", int'(got_last[229]), 1);
      chk("ab_last_b_pos", int'(got_last[239]), 1);
    end

    // Random back-pressure and sample gaps
    do_reset();
    out_ready = 1'b1;
    send(300, 1'b0, 1'b0, 1'b0);
    send(200, 1'b1, 1'b1, 1'b1);
    drain(1'b1);
    $display("[TB] random-ready session words=%0d", got_data.size());
    exp.delete();
    for (int i = 0; i < 500; i++) exp.push_back(i);
    chk("rnd_seq_mismatches", seq_mismatch(exp), 0);
    chk("rnd_nlast", count_lasts(), 1);
    if (got_last.size() > 0) chk("rnd_lastflag", int'(got_last[got_last.size()-1]), 1);

    // Reset in mid-session, then a session with no history
    do_reset();
    out_ready = 1'b1;
    send(1000, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(20, 1'b1, 1'b0, 1'b0);
    chk("rst_pre_out_valid", int'(out_valid), 1);
    recording_active = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_overflow", int'(overflow), 0);
    chk("rst_mid_fill_level", int'(fill_level), 0);
    tick();
    rst = 1'b0;
    chk("rst_no_last_emitted", count_lasts(), 0);
    tick();
    got_data.delete();
    got_last.delete();
    out_ready = 1'b1;
    send(5, 1'b1, 1'b0, 1'b0);
    drain(1'b0);
    $display("[TB] post-reset session words=%0d", got_data.size());
    exp.delete();
    for (int i = 1020; i < 1025; i++) exp.push_back(i);
    chk("rst_after_seq_mismatches", seq_mismatch(exp), 0);
    chk("rst_after_nlast", count_lasts(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
